// File: rtl/banked_status_register_if.sv
// Flag/exception port bundle between the EX stage, the exception unit and the
// banked status register. Clock and reset stay as plain ports on the block.
interface banked_status_register_if #(
    parameter int FLAG_W    = 4,
    parameter int NUM_BANKS = 4
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic [FLAG_W-1:0] status_input;
    logic [FLAG_W-1:0] flag_wr_mask;
    logic              do_update_sr;
    logic [FLAG_W-1:0] spsr_input;
    logic              spsr_wr;
    logic              exc_enter;
    logic [BANK_W-1:0] exc_bank;
    logic              exc_return;
    logic [FLAG_W-1:0] status_output;
    logic [FLAG_W-1:0] spsr_output;
    logic [BANK_W-1:0] cur_bank;
    logic              bank_err;

    modport master (
        output status_input, flag_wr_mask, do_update_sr,
        output spsr_input, spsr_wr,
        output exc_enter, exc_bank, exc_return,
        input  status_output, spsr_output, cur_bank, bank_err
    );

    modport slave (
        input  status_input, flag_wr_mask, do_update_sr,
        input  spsr_input, spsr_wr,
        input  exc_enter, exc_bank, exc_return,
        output status_output, spsr_output, cur_bank, bank_err
    );
endinterface

// File: rtl/banked_status_register.sv
// Status flags with one saved-status slot per privileged bank. Supports masked
// flag updates, exception entry (save + switch) and return (restore + switch back).
module banked_status_register #(
    parameter int FLAG_W    = 4,
    parameter int NUM_BANKS = 4
) (
    input logic                     clk,
    input logic                     rst,
    banked_status_register_if.slave bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic [FLAG_W-1:0] status_q;
    logic [BANK_W-1:0] cur_bank_q;
    logic              bank_err_q;

    // Slot 0 belongs to the user bank; it is never written outside reset and never read.
    logic [FLAG_W-1:0] saved_flags [NUM_BANKS];
    logic [BANK_W-1:0] saved_bank  [NUM_BANKS];

    logic bank_legal;
    logic in_user_bank;
    logic enter_ok;
    logic return_ok;
    logic update_ok;
    logic spsr_ok;
    logic err_next;

    // Priority decode: an asserted exc_enter swallows everything below it even when
    // its target bank is illegal, and exc_return likewise swallows the update path.
    always_comb begin
        bank_legal   = 1'b0;
        in_user_bank = 1'b0;
        enter_ok     = 1'b0;
        return_ok    = 1'b0;
        update_ok    = 1'b0;
        spsr_ok      = 1'b0;
        err_next     = 1'b0;

        bank_legal   = (bus.exc_bank != '0) && (int'(bus.exc_bank) < NUM_BANKS);
        in_user_bank = (cur_bank_q == '0);

        if (bus.exc_enter) begin
            enter_ok = bank_legal;
            err_next = !bank_legal;
        end else if (bus.exc_return) begin
            return_ok = !in_user_bank;
            err_next  = in_user_bank;
        end else begin
            update_ok = bus.do_update_sr;
            spsr_ok   = bus.spsr_wr && !in_user_bank;
            err_next  = bus.spsr_wr && in_user_bank;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            status_q   <= '0;
            cur_bank_q <= '0;
            bank_err_q <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                saved_flags[b] <= '0;
                saved_bank[b]  <= '0;
            end
        end else begin
            bank_err_q <= err_next;
            if (enter_ok) begin
                saved_flags[bus.exc_bank] <= status_q;
                saved_bank[bus.exc_bank]  <= cur_bank_q;
                cur_bank_q                <= bus.exc_bank;
            end else if (return_ok) begin
                status_q   <= saved_flags[cur_bank_q];
                cur_bank_q <= saved_bank[cur_bank_q];
            end else begin
                if (update_ok) begin
                    status_q <= (status_q & ~bus.flag_wr_mask) |
                                (bus.status_input & bus.flag_wr_mask);
                end
                if (spsr_ok) begin
                    saved_flags[cur_bank_q] <= bus.spsr_input;
                end
            end
        end
    end

    assign bus.status_output = status_q;
    assign bus.spsr_output   = (cur_bank_q == '0) ? '0 : saved_flags[cur_bank_q];
    assign bus.cur_bank      = cur_bank_q;
    assign bus.bank_err      = bank_err_q;
endmodule

// File: tb/tb_banked_status_register.sv
// Directed-vector bench for banked_status_register (FLAG_W=4, NUM_BANKS=4).
// State commits on the falling edge; outputs are checked 1 time unit after it.
module tb_banked_status_register;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    banked_status_register_if #(.FLAG_W(4), .NUM_BANKS(4)) bus ();

    banked_status_register #(.FLAG_W(4), .NUM_BANKS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] status_input;
        logic [3:0] mask;
        logic       upd;
        logic [3:0] spsr_input;
        logic       spsr_wr;
        logic       enter;
        logic [1:0] ebank;
        logic       ret;
        logic [3:0] exp_status;
        logic [3:0] exp_spsr;
        logic [1:0] exp_bank;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string n, logic r, logic [3:0] sin, logic [3:0] m, logic u,
                                logic [3:0] sp, logic sw, logic en, logic [1:0] eb, logic rt,
                                logic [3:0] es, logic [3:0] esp, logic [1:0] ebk, logic ee);
        vec_t v;
        v.name = n; v.rst = r; v.status_input = sin; v.mask = m; v.upd = u;
        v.spsr_input = sp; v.spsr_wr = sw; v.enter = en; v.ebank = eb; v.ret = rt;
        v.exp_status = es; v.exp_spsr = esp; v.exp_bank = ebk; v.exp_err = ee;
        return v;
    endfunction

    // Inputs change just after the rising edge, are held across the committing
    // falling edge, and the strobes are dropped right after it.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        rst                 = v.rst;
        bus.status_input    = v.status_input;
        bus.flag_wr_mask    = v.mask;
        bus.do_update_sr    = v.upd;
        bus.spsr_input      = v.spsr_input;
        bus.spsr_wr         = v.spsr_wr;
        bus.exc_enter       = v.enter;
        bus.exc_bank        = v.ebank;
        bus.exc_return      = v.ret;
        @(negedge clk);
        #1;
    endtask

    task automatic clearStrobes();
        rst              = 1'b0;
        bus.do_update_sr = 1'b0;
        bus.spsr_wr      = 1'b0;
        bus.exc_enter    = 1'b0;
        bus.exc_return   = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] es, input logic [3:0] esp,
                               input logic [1:0] ebk, input logic ee);
        tests_run++;
        if (bus.status_output !== es || bus.spsr_output !== esp ||
            bus.cur_bank !== ebk || bus.bank_err !== ee) begin
            tests_failed++;
            $display("[TB] FAIL %s: got status=%b spsr=%b bank=%0d err=%b, expected status=%b spsr=%b bank=%0d err=%b",
                     name, bus.status_output, bus.spsr_output, bus.cur_bank, bus.bank_err,
                     es, esp, ebk, ee);
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkOutput(v.name, v.exp_status, v.exp_spsr, v.exp_bank, v.exp_err);
        clearStrobes();
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        rst              = 1'b1;
        bus.status_input = '0;
        bus.flag_wr_mask = '0;
        bus.do_update_sr = 1'b0;
        bus.spsr_input   = '0;
        bus.spsr_wr      = 1'b0;
        bus.exc_enter    = 1'b0;
        bus.exc_bank     = '0;
        bus.exc_return   = 1'b0;

        //                 name              rst sin      mask     upd spin     sw   ent eb     ret   status   spsr     bank   err
        vecs.push_back(mk("reset",           1, 4'b0000, 4'b0000, 0, 4'b0000, 0,   0, 2'd0, 0,    4'b0000, 4'b0000, 2'd0, 0));
        vecs.push_back(mk("mask_0101",       0, 4'b1111, 4'b0101, 1, 4'b0000, 0,   0, 2'd0, 0,    4'b0101, 4'b0000, 2'd0, 0));
        vecs.push_back(mk("mask_zero",       0, 4'b1010, 4'b0000, 1, 4'b0000, 0,   0, 2'd0, 0,    4'b0101, 4'b0000, 2'd0, 0));
        vecs.push_back(mk("flags_1010",      0, 4'b1010, 4'b1111, 1, 4'b0000, 0,   0, 2'd0, 0,    4'b1010, 4'b0000, 2'd0, 0));
        vecs.push_back(mk("enter_b2",        0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   1, 2'd2, 0,    4'b1010, 4'b1010, 2'd2, 0));
        vecs.push_back(mk("b2_update",       0, 4'b0001, 4'b1111, 1, 4'b0000, 0,   0, 2'd0, 0,    4'b0001, 4'b1010, 2'd2, 0));
        vecs.push_back(mk("return_b2",       0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   0, 2'd0, 1,    4'b1010, 4'b0000, 2'd0, 0));
        vecs.push_back(mk("nest_flags",      0, 4'b0011, 4'b1111, 1, 4'b0000, 0,   0, 2'd0, 0,    4'b0011, 4'b0000, 2'd0, 0));
        vecs.push_back(mk("nest_enter1",     0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   1, 2'd1, 0,    4'b0011, 4'b0011, 2'd1, 0));
        vecs.push_back(mk("nest_b1_flags",   0, 4'b1100, 4'b1111, 1, 4'b0000, 0,   0, 2'd0, 0,    4'b1100, 4'b0011, 2'd1, 0));
        vecs.push_back(mk("nest_enter3",     0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   1, 2'd3, 0,    4'b1100, 4'b1100, 2'd3, 0));
        vecs.push_back(mk("nest_ret_to1",    0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   0, 2'd0, 1,    4'b1100, 4'b0011, 2'd1, 0));
        vecs.push_back(mk("nest_ret_to0",    0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   0, 2'd0, 1,    4'b0011, 4'b0000, 2'd0, 0));
        vecs.push_back(mk("enter_vs_upd",    0, 4'b1111, 4'b1111, 1, 4'b0000, 0,   1, 2'd1, 0,    4'b0011, 4'b0011, 2'd1, 0));
        vecs.push_back(mk("b1_flags_0110",   0, 4'b0110, 4'b1111, 1, 4'b0000, 0,   0, 2'd0, 0,    4'b0110, 4'b0011, 2'd1, 0));
        vecs.push_back(mk("enter_vs_ret",    0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   1, 2'd2, 1,    4'b0110, 4'b0110, 2'd2, 0));
        vecs.push_back(mk("ret_b2_to_b1",    0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   0, 2'd0, 1,    4'b0110, 4'b0011, 2'd1, 0));
        vecs.push_back(mk("spsr_and_upd",    0, 4'b1000, 4'b1000, 1, 4'b1001, 1,   0, 2'd0, 0,    4'b1110, 4'b1001, 2'd1, 0));
        vecs.push_back(mk("ret_drops_spsr",  0, 4'b0000, 4'b0000, 0, 4'b1111, 1,   0, 2'd0, 1,    4'b1001, 4'b0000, 2'd0, 0));
        vecs.push_back(mk("enter_b3",        0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   1, 2'd3, 0,    4'b1001, 4'b1001, 2'd3, 0));
        vecs.push_back(mk("b3_flags_0100",   0, 4'b0100, 4'b1111, 1, 4'b0000, 0,   0, 2'd0, 0,    4'b0100, 4'b1001, 2'd3, 0));
        vecs.push_back(mk("reenter_b3",      0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   1, 2'd3, 0,    4'b0100, 4'b0100, 2'd3, 0));
        vecs.push_back(mk("spsr_wr_b3",      0, 4'b0000, 4'b0000, 0, 4'b0010, 1,   0, 2'd0, 0,    4'b0100, 4'b0010, 2'd3, 0));
        vecs.push_back(mk("ret_self_b3",     0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   0, 2'd0, 1,    4'b0010, 4'b0010, 2'd3, 0));
        vecs.push_back(mk("rst_overrides",   1, 4'b1111, 4'b1111, 1, 4'b1111, 1,   1, 2'd1, 1,    4'b0000, 4'b0000, 2'd0, 0));
        vecs.push_back(mk("ill_ret_b0",      0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   0, 2'd0, 1,    4'b0000, 4'b0000, 2'd0, 1));
        vecs.push_back(mk("err_clears",      0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   0, 2'd0, 0,    4'b0000, 4'b0000, 2'd0, 0));
        vecs.push_back(mk("flags_0111",      0, 4'b0111, 4'b1111, 1, 4'b0000, 0,   0, 2'd0, 0,    4'b0111, 4'b0000, 2'd0, 0));
        vecs.push_back(mk("ill_enter_b0",    0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   1, 2'd0, 0,    4'b0111, 4'b0000, 2'd0, 1));
        vecs.push_back(mk("ill_spsr_b0",     0, 4'b0000, 4'b0000, 0, 4'b1111, 1,   0, 2'd0, 0,    4'b0111, 4'b0000, 2'd0, 1));
        vecs.push_back(mk("err_clears2",     0, 4'b0000, 4'b0000, 0, 4'b0000, 0,   0, 2'd0, 0,    4'b0111, 4'b0000, 2'd0, 0));

        foreach (vecs[i]) runVec(vecs[i]);

        // Reset in the middle of an exception: saved context must be gone afterwards.
        runVec(mk("mid_enter_b2",   0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 2'd2, 0, 4'b0111, 4'b0111, 2'd2, 0));
        runVec(mk("mid_rst",        1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 4'b0000, 2'd0, 0));
        runVec(mk("mid_ret_ill",    0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2'd0, 1, 4'b0000, 4'b0000, 2'd0, 1));
        runVec(mk("mid_err_clears", 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 4'b0000, 2'd0, 0));

        // Held illegal request: the error repeats each edge, then drops the edge after release.
        runVec(mk("hold_ill_1",     0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2'd0, 1, 4'b0000, 4'b0000, 2'd0, 1));
        runVec(mk("hold_ill_2",     0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2'd0, 1, 4'b0000, 4'b0000, 2'd0, 1));
        runVec(mk("hold_release",   0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 4'b0000, 2'd0, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
